// File: rtl/mem_arbiter.sv
// Memory arbiter: shares a single RAM port among CPUS instruction/data cache pairs.
// Data requests win over instruction requests. Within one request type the grant
// rotates round-robin. Errors and stuck transactions raise a sticky error flag.
module mem_arbiter #(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [32*CPUS-1:0]   iaddr,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [32*CPUS-1:0]   daddr,
    input  logic [32*CPUS-1:0]   dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [32*CPUS-1:0]   iload,
    output logic [32*CPUS-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate,
    output logic                 merror
);

    localparam int          IW         = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;
    localparam logic [31:0] TLAST      = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DSERVE, ISERVE} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_rrPtr;
    logic [31:0]     r_timer;
    logic            r_merror;

    logic            w_dAny;
    logic            w_iAny;
    logic [IW-1:0]   w_dGrant;
    logic [IW-1:0]   w_iGrant;
    logic            w_ownReq;
    logic            w_done;
    logic            w_setErr;
    logic            w_timerInc;

    // Every cache sees the RAM read data; only the deasserted wait tells it the word is valid.
    assign iload  = {CPUS{ramload}};
    assign dload  = {CPUS{ramload}};
    assign merror = r_merror;

    // Round-robin search starting at r_rrPtr, separately for data and instruction requesters.
    always_comb begin
        int idx;
        idx      = 0;
        w_dAny   = 1'b0;
        w_iAny   = 1'b0;
        w_dGrant = '0;
        w_iGrant = '0;
        for (int k = 0; k < CPUS; k++) begin
            idx = int'(r_rrPtr) + k;
            if (idx >= CPUS) idx = idx - CPUS;
            if (!w_dAny && (dREN[idx] || dWEN[idx])) begin
                w_dAny   = 1'b1;
                w_dGrant = IW'(idx);
            end
            if (!w_iAny && iREN[idx]) begin
                w_iAny   = 1'b1;
                w_iGrant = IW'(idx);
            end
        end
    end

    // Next-state logic and RAM/wait outputs; abort beats ACCESS, ERROR and timeout.
    always_comb begin
        w_nextState = r_state;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = '1;
        dwait       = '1;
        w_ownReq    = 1'b0;
        w_done      = 1'b0;
        w_setErr    = 1'b0;
        w_timerInc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dAny)      w_nextState = DSERVE;
                else if (w_iAny) w_nextState = ISERVE;
            end
            DSERVE: begin
                ramaddr  = daddr[32*r_owner +: 32];
                ramstore = dstore[32*r_owner +: 32];
                if (dWEN[r_owner]) ramWEN = 1'b1;
                else               ramREN = 1'b1;
                w_ownReq = dREN[r_owner] || dWEN[r_owner];
            end
            ISERVE: begin
                ramREN   = 1'b1;
                ramaddr  = iaddr[32*r_owner +: 32];
                w_ownReq = iREN[r_owner];
            end
            default: w_nextState = IDLE;
        endcase
        if (r_state == DSERVE || r_state == ISERVE) begin
            if (!w_ownReq) begin
                w_nextState = IDLE;
                w_done      = 1'b1;
            end else if (ramstate == RAM_ACCESS) begin
                if (r_state == DSERVE) dwait[r_owner] = 1'b0;
                else                   iwait[r_owner] = 1'b0;
                w_nextState = IDLE;
                w_done      = 1'b1;
            end else if (ramstate == RAM_ERROR || r_timer == TLAST) begin
                w_setErr    = 1'b1;
                w_nextState = IDLE;
                w_done      = 1'b1;
            end else begin
                w_timerInc  = 1'b1;
            end
        end
    end

    // State register and owner capture at the moment a grant leaves IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_nextState != IDLE)
                r_owner <= w_dAny ? w_dGrant : w_iGrant;
        end
    end

    // Round-robin pointer moves past the owner whenever its transaction ends for any reason.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_rrPtr <= '0;
        else if (w_done)
            r_rrPtr <= (r_owner == IW'(CPUS - 1)) ? '0 : r_owner + 1'b1;
    end

    // Stall counter: held at zero while idle, counts serving cycles that saw neither ACCESS nor ERROR.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_timer <= '0;
        else if (r_state == IDLE || w_done)
            r_timer <= '0;
        else if (w_timerInc)
            r_timer <= r_timer + 32'd1;
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_merror <= 1'b0;
        else if (w_setErr)
            r_merror <= 1'b1;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CPUS, default 2: number of cache pairs served; 1..4.
REQ-002 Parameter TIMEOUT, default 15: max consecutive ramstate BUSY/FREE cycles tolerated per granted transaction.
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 iREN  in  CPUS  per-CPU instruction read request.
REQ-006 iaddr  in  32*CPUS  per-CPU instruction word address.
REQ-007 dREN / dWEN  in  CPUS each  per-CPU data read / write request.
REQ-008 daddr / dstore  in  32*CPUS each  per-CPU data address / write data.
REQ-009 iwait / dwait  out  CPUS each  per-CPU stall; 0 only in completing cycle.
REQ-010 iload / dload  out  32*CPUS each  per-CPU returned word.
REQ-011 ramREN / ramWEN  out  1 each  RAM read / write strobe.
REQ-012 ramaddr / ramstore  out  32 each  RAM address / write data.
REQ-013 ramload  in  32  RAM read data.
REQ-014 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-015 merror  out  1  sticky error flag (RAM ERROR or timeout).

Function
REQ-016 FSM states IDLE, DSERVE, ISERVE; owner register (CPU index) and type latched on leaving IDLE.
REQ-017 IDLE: any CPU with dREN|dWEN -> DSERVE; else any iREN -> ISERVE; else stay IDLE.
REQ-018 Data requests beat instruction requests in the same cycle, from any CPU.
REQ-019 Among CPUs of same request type, round-robin: search starts at rr_ptr, first requester wins.
REQ-020 rr_ptr advances to (owner+1) mod CPUS on every completed or aborted transaction.
REQ-021 No RAM strobes in IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
REQ-022 DSERVE: ramaddr=daddr[owner], ramstore=dstore[owner]; dWEN[owner]=1 -> ramWEN=1, ramREN=0; else ramREN=1.
REQ-023 dREN and dWEN both high on owner: treated as write.
REQ-024 ISERVE: ramREN=1, ramWEN=0, ramaddr=iaddr[owner], ramstore=0.
REQ-025 RAM signals driven combinationally from owner inputs each cycle; address change mid-service passes through.
REQ-026 ramstate ACCESS while serving: owner's matching wait=0 for that cycle only; next state IDLE.
REQ-027 Owner drops its request (DSERVE: dREN=dWEN=0; ISERVE: iREN=0): abort, next state IDLE, no wait deasserted.
REQ-028 ramstate ERROR while serving: wait stays 1, merror set, next state IDLE (cache retries).
REQ-029 Timeout counter clears on entering DSERVE/ISERVE, increments each serving cycle without ACCESS/ERROR; reaching TIMEOUT: merror set, next state IDLE.
REQ-030 Abort (REQ-027) takes priority over ACCESS, ERROR and timeout in the same cycle.
REQ-031 iload[k]=dload[k]=ramload for every k, combinationally.
REQ-032 iwait/dwait=1 for all non-owner CPUs and all types at all times except REQ-026.
REQ-033 Completing transaction uses one ACCESS cycle; minimum latency request-to-wait-low = 2 cycles (grant cycle + ACCESS cycle).
REQ-034 merror cleared only by reset.

Reset
REQ-035 nRST low: state IDLE, owner=0, rr_ptr=0, timeout counter=0, merror=0, immediately, independent of CLK.
REQ-036 During and right after reset: all iwait/dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-037 Reset asserted mid-transaction discards it; no wait deasserted for the aborted request.

Verification
REQ-038 CPU0 dWEN=1, daddr=0x100, dstore=0xDEADBEEF; ramstate BUSY x2 then ACCESS -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF; dwait[0]=0 exactly in ACCESS cycle.
REQ-039 Same cycle: CPU0 iREN addr 0x0, CPU1 dREN addr 0x200 -> DSERVE for CPU1 first, then ISERVE for CPU0; ramaddr 0x200 then 0x0.
REQ-040 CPU0 and CPU1 both dREN continuously, ramstate ACCESS each serving cycle -> grants alternate 0,1,0,1.
REQ-041 ramstate held BUSY with TIMEOUT=15 -> after 15 serving cycles merror=1, FSM IDLE, dwait stays 1; re-grant follows.
REQ-042 ramstate ERROR during ISERVE -> iwait stays 1, merror=1; nRST pulse -> merror=0, all waits 1.
REQ-043 CPU0 drops iREN on same cycle ramstate=ACCESS -> no iwait deassert, FSM IDLE, rr_ptr=1.
